// File: rtl/display_pkg.sv
// Shared types and constants for the ecall print display path.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  localparam int BIN_W  = 32;
  localparam int BCD_N  = 10;
  localparam int BCD_W  = 4 * BCD_N;
  localparam int DISP_N = 8;
  localparam int DISP_W = 4 * DISP_N;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Packed so that SEG_DIGIT[d] is the pattern for digit d.
  localparam logic [9:0][7:0] SEG_DIGIT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [BCD_W-1:0] dd_adjust(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_N; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low seven-segment pattern.
// Dash wins over blank; non-decimal nibbles render blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash)
      seg = SEG_DASH;
    else if (!blank && bcd <= 4'd9)
      seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/print_display.sv
// Ecall print back-end: double-dabble conversion of a0 and
// a multiplexed 8-digit seven-segment scan with blanking.
module print_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIGITS      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              renew,
  input  logic [31:0]       value,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              overflow
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

  state_t            state, state_n;
  logic [BIN_W-1:0]  sh, sh_n;
  logic [BCD_W-1:0]  bcd, bcd_n;
  logic [4:0]        step, step_n;
  logic              pend, pend_n;
  logic [BIN_W-1:0]  pval, pval_n;
  logic [DISP_W-1:0] disp, disp_n;
  logic              ovf, ovf_n;
  logic [RW-1:0]     rcnt, rcnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [IW-1:0]     msd;
  logic [7:0]        seg_n;

  always_comb begin
    state_n = state;
    sh_n    = sh;
    bcd_n   = bcd;
    step_n  = step;
    pend_n  = pend;
    pval_n  = pval;
    disp_n  = disp;
    ovf_n   = ovf;
    unique case (state)
      IDLE: begin
        if (renew) begin
          sh_n    = value;
          bcd_n   = '0;
          step_n  = '0;
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_n, sh_n} = {dd_adjust(bcd), sh} << 1;
        step_n = step + 5'd1;
        if (step == 5'd31)
          state_n = COMMIT;
        if (renew) begin
          pend_n = 1'b1;
          pval_n = value;
        end
      end
      COMMIT: begin
        disp_n = bcd[DISP_W-1:0];
        ovf_n  = |bcd[BCD_W-1:DISP_W];
        // A request landing on this cycle is newer than pval.
        if (pend || renew) begin
          sh_n    = renew ? value : pval;
          bcd_n   = '0;
          step_n  = '0;
          pend_n  = 1'b0;
          state_n = CONVERT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rcnt_n = rcnt + RW'(1);
    idx_n  = idx;
    if (rcnt == RMAX) begin
      rcnt_n = '0;
      idx_n  = idx + IW'(1);
    end
  end

  always_comb begin
    msd = '0;
    for (int i = 1; i < DISP_N; i++) begin
      if (disp_n[4*i +: 4] != 4'd0)
        msd = IW'(i);
    end
  end

  // Decode from next-state values so seg and an flip on one edge.
  seg7_decode u_dec (
    .bcd   (disp_n[{idx_n, 2'b00} +: 4]),
    .blank (idx_n > msd),
    .dash  (ovf_n),
    .seg   (seg_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sh    <= '0;
      bcd   <= '0;
      step  <= '0;
      pend  <= 1'b0;
      pval  <= '0;
      disp  <= '0;
      ovf   <= 1'b0;
      rcnt  <= '0;
      idx   <= '0;
      seg   <= SEG_DIGIT[0];
      an    <= ~DIGITS'(1);
    end else begin
      state <= state_n;
      sh    <= sh_n;
      bcd   <= bcd_n;
      step  <= step_n;
      pend  <= pend_n;
      pval  <= pval_n;
      disp  <= disp_n;
      ovf   <= ovf_n;
      rcnt  <= rcnt_n;
      idx   <= idx_n;
      seg   <= seg_n;
      an    <= ~(DIGITS'(1) << idx_n);
    end
  end

  assign busy     = (state != IDLE);
  assign overflow = ovf;

endmodule

// File: tb/tb_print_display.sv
// Randomized bench for print_display against a decimal-arithmetic
// model; two instances cover slow and fast scan rates.
module tb_print_display;

  logic        clk;
  logic        rst;
  logic        renew;
  logic [31:0] value;

  logic [7:0] seg_a, an_a, seg_b, an_b;
  logic       busy_a, ovf_a, busy_b, ovf_b;

  int n_cmp;
  int n_bad;

  bit      m_act;
  bit      m_pend;
  int      m_rem;
  longint  m_cur;
  longint  m_pv;
  longint  m_disp;
  bit      m_ovf;
  int      m_n;

  logic [7:0] segtab [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  print_display #(.REFRESH_DIV(4), .DIGITS(8)) u_a (
    .clk      (clk),
    .rst      (rst),
    .renew    (renew),
    .value    (value),
    .seg      (seg_a),
    .an       (an_a),
    .busy     (busy_a),
    .overflow (ovf_a)
  );

  print_display #(.REFRESH_DIV(2), .DIGITS(8)) u_b (
    .clk      (clk),
    .rst      (rst),
    .renew    (renew),
    .value    (value),
    .seg      (seg_b),
    .an       (an_b),
    .busy     (busy_b),
    .overflow (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each request needs 33 edges; the 33rd publishes the result.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act  <= 1'b0;
      m_pend <= 1'b0;
      m_rem  <= 0;
      m_disp <= 0;
      m_ovf  <= 1'b0;
      m_n    <= 0;
    end else begin
      m_n <= m_n + 1;
      if (!m_act) begin
        if (renew) begin
          m_act <= 1'b1;
          m_rem <= 32;
          m_cur <= longint'(value);
        end
      end else if (m_rem == 0) begin
        m_disp <= m_cur % 100000000;
        m_ovf  <= (m_cur > 99999999);
        if (m_pend || renew) begin
          m_cur  <= renew ? longint'(value) : m_pv;
          m_pend <= 1'b0;
          m_rem  <= 32;
        end else begin
          m_act <= 1'b0;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (renew) begin
          m_pend <= 1'b1;
          m_pv   <= longint'(value);
        end
      end
    end
  end

  function automatic logic [7:0] exp_seg(
    input longint d, input bit o, input int pos
  );
    longint t;
    int     nd;
    int     dig;
    if (o) return 8'hBF;
    nd = 1;
    t  = d / 10;
    while (t != 0) begin
      nd++;
      t = t / 10;
    end
    if (pos >= nd) return 8'hFF;
    t = d;
    for (int k = 0; k < pos; k++) t = t / 10;
    dig = int'(t % 10);
    return segtab[dig];
  endfunction

  task automatic chk(
    input string nm, input logic [7:0] got, input logic [7:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int ia;
    int ib;
    ia = (m_n / 4) % 8;
    ib = (m_n / 2) % 8;
    chk("busy_a", {7'd0, busy_a}, {7'd0, m_act});
    chk("busy_b", {7'd0, busy_b}, {7'd0, m_act});
    chk("ovf_a", {7'd0, ovf_a}, {7'd0, m_ovf});
    chk("ovf_b", {7'd0, ovf_b}, {7'd0, m_ovf});
    chk("an_a", an_a, ~(8'd1 << ia));
    chk("an_b", an_b, ~(8'd1 << ib));
    chk("seg_a", seg_a, exp_seg(m_disp, m_ovf, ia));
    chk("seg_b", seg_b, exp_seg(m_disp, m_ovf, ib));
  end

  task automatic step(input bit r, input logic [31:0] v);
    renew = r;
    value = v;
    @(negedge clk);
    #1;
    renew = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0);
  endtask

  // Wait for a slot on the slow instance, then pin its pattern.
  task automatic lit_slot(
    input string nm, input logic [7:0] want_an, input logic [7:0] want
  );
    int k;
    k = 0;
    while (an_a !== want_an && k < 64) begin
      idle(1);
      k++;
    end
    if (k >= 64) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s slot timeout an=%h want=%h", nm, an_a, want_an);
    end else begin
      chk(nm, seg_a, want);
    end
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] edge_v [6] = '{
      32'd0, 32'd9, 32'd10, 32'd99999999,
      32'd100000000, 32'hFFFFFFFF
    };
    unique case ($urandom_range(0, 3))
      0: return $urandom_range(0, 999);
      1: return $urandom % 100000000;
      2: return $urandom;
      default: return edge_v[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cur = 0;
    m_pv  = 0;
    rst   = 1'b0;
    renew = 1'b0;
    value = 32'd0;
    @(negedge clk);
    #1;
    idle(3);
    chk("rst_an", an_a, 8'hFE);
    chk("rst_seg", seg_a, 8'hC0);
    chk("rst_busy", {7'd0, busy_a}, 8'd0);
    chk("rst_ovf", {7'd0, ovf_a}, 8'd0);
    rst = 1'b1;
    idle(10);

    step(1'b1, 32'd1234);
    idle(40);
    lit_slot("d0_1234", 8'hFE, 8'h99);
    lit_slot("d3_1234", 8'hF7, 8'hF9);
    lit_slot("d4_1234", 8'hEF, 8'hFF);

    step(1'b1, 32'd99999999);
    idle(40);
    lit_slot("d7_9s", 8'h7F, 8'h90);
    chk("ovf_9s", {7'd0, ovf_a}, 8'd0);

    step(1'b1, 32'd100000000);
    idle(40);
    lit_slot("d0_ovf", 8'hFE, 8'hBF);
    chk("ovf_1e8", {7'd0, ovf_a}, 8'd1);

    step(1'b1, 32'd5678);
    idle(9);
    step(1'b1, 32'd42);
    step(1'b1, 32'd7);
    idle(80);
    lit_slot("d0_7", 8'hFE, 8'hF8);
    lit_slot("d1_7", 8'hFD, 8'hFF);

    step(1'b1, 32'd777);
    idle(15);
    rst = 1'b0;
    idle(2);
    chk("mid_busy", {7'd0, busy_a}, 8'd0);
    chk("mid_seg", seg_a, 8'hC0);
    rst = 1'b1;
    idle(40);
    lit_slot("d0_after", 8'hFE, 8'hC0);
    lit_slot("d2_after", 8'hFB, 8'hFF);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
      end
      step($urandom_range(0, 15) == 0, rand_val());
    end
    idle(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
